// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;
  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        filled;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory request/response, redirect and instruction-delivery signals of the fetch stage.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order buffer of fetched words: entries are allocated at grant, filled on
// response and popped by the datapath; flush discards everything at once.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_i,
  input  logic [31:0]                  alloc_pc_i,
  input  logic                         fill_i,
  input  logic [31:0]                  fill_word_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [$clog2(DEPTH+1)-1:0]   unfilled_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     entries_q [DEPTH];
  fetch_entry_t     entries_d [DEPTH];
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] unfilled_q,  unfilled_d;

  assign head_o     = entries_q[head_ptr_q];
  assign count_o    = count_q;
  assign unfilled_o = unfilled_q;

  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    unfilled_d  = unfilled_q;
    if (flush_i) begin
      // Stale pc/word contents stay behind; only the filled flags matter.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_d[PTR_W'(i)].filled = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      unfilled_d  = '0;
    end else begin
      if (alloc_i) begin
        entries_d[alloc_ptr_q] = '{pc: alloc_pc_i, word: INST_NOP, filled: 1'b0};
        alloc_ptr_d            = alloc_ptr_q + PTR_W'(1);
      end
      if (fill_i) begin
        entries_d[fill_ptr_q].word   = fill_word_i;
        entries_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d                   = fill_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        entries_d[head_ptr_q].filled = 1'b0;
        head_ptr_d                   = head_ptr_q + PTR_W'(1);
      end
      count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[PTR_W'(i)] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else begin
      entries_q   <= entries_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      unfilled_q  <= unfilled_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads and
// delivers PC-tagged words to the datapath; redirects flush and drop stale data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_q,     drop_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] unfilled;
  fetch_entry_t     head;
  logic             issue_c;
  logic             xfer;
  logic             fill;
  logic             pop;

  // Registered occupancy gates issue, so a same-cycle pop frees nothing yet.
  assign issue_c = !rst && (count < CNT_W'(DEPTH)) && !bus.redirect && (drop_q == '0);
  assign xfer    = issue_c && bus.imem_gnt;
  assign fill    = bus.imem_rvalid && (drop_q == '0);
  assign pop     = head.filled && bus.inst_ready;

  assign bus.imem_req   = issue_c;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head.filled;
  assign bus.inst       = head.word;
  assign bus.inst_pc    = head.pc;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (xfer),
    .alloc_pc_i  (fetch_pc_q),
    .fill_i      (fill),
    .fill_word_i (bus.imem_rdata),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .head_o      (head),
    .count_o     (count),
    .unfilled_o  (unfilled)
  );

  // Every response still owed at a redirect becomes one to drop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      drop_d     = unfilled + drop_q - CNT_W'(bus.imem_rvalid);
    end else begin
      if (xfer) begin
        fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
      end
      if (bus.imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> ((drop_q != '0) || (unfilled != '0)));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle datapath. It owns the fetch program counter and issues in-order word reads to instruction memory over a request/grant handshake. It buffers returned words, each tagged with its PC, in a small queue and presents them to the datapath under valid/ready. Taken branches, jumps, jal and jr from the datapath arrive as a single redirect; on a redirect the unit flushes the queue and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, queue entries (power of two, ≥2); 4 sustains 1 inst/cycle at 1-cycle memory latency
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request valid
- imem_addr  out  32  word address of request, bits [1:0] always 0
- imem_gnt  in  1  memory accepts request this cycle (transfer = imem_req & imem_gnt)
- imem_rvalid  in  1  read data returned (in request order, ≥1 cycle after grant)
- imem_rdata  in  32  returned instruction word
- redirect  in  1  datapath requests fetch from redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst  out  32  instruction word
- inst_pc  out  32  address of inst
- inst_ready  in  1  datapath consumes instruction (transfer = inst_valid & inst_ready)

## Operation
- State: fetch_pc (32), queue of DEPTH entries {pc, word, filled}, alloc/fill/head pointers, occupancy count, drop counter (width clog2(DEPTH+1)).
- Reset values: fetch_pc = RESET_PC, queue empty, drop = 0; outputs imem_req 0, imem_addr = RESET_PC, inst_valid 0, inst 0, inst_pc 0.
- Issue: imem_req = !rst & (occupancy < DEPTH) & !redirect & (drop == 0); imem_addr = fetch_pc. Occupancy is the registered value; a same-cycle pop does not free a slot until the next cycle.
- On transfer: allocate entry at alloc pointer with pc = fetch_pc and filled = 0; fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC → 0).
- Fill: imem_rvalid with drop == 0 writes imem_rdata into the entry at the fill pointer and sets filled. With drop > 0 the response is discarded and drop decrements.
- Output: inst_valid = head entry filled, driven from registers; inst/inst_pc = head entry; pop on inst_valid & inst_ready.
- Redirect (highest priority): fetch_pc ← {redirect_pc[31:2],2'b00}; queue cleared; drop ← (allocated-unfilled entries) − (1 if a kept response arrives this cycle) + current drop − (1 if a dropped response arrives). A same-cycle pop is treated as consumed. No request is issued in the redirect cycle.
- Responses arriving with queue empty and drop == 0 are a protocol error (assertion); imem_rvalid is never asserted after rst since memory shares rst.

## Timing
- First request: cycle after rst deasserts, addr RESET_PC.
- Latency: grant at t, rvalid at t+1 → inst_valid at t+2.
- Redirect at t: first new request at t+1 with drop == 0; otherwise once drop reaches 0. inst_valid is 0 from t+1 until the new data is filled.
- Reset asserted mid-operation: all state clears immediately (async), in-flight data is lost.
- Full queue: imem_req held 0; fetch_pc stable; no data lost.

## Structure
- Package fetch_pkg: RESET_PC default, INST_NOP = 32'h0000_0000, WORD_BYTES = 4, entry struct {pc, word, filled}.
- Sub-module fetch_queue: entry array with alloc/fill/pop/flush and occupancy/unfilled counts; fetch_unit holds the PC, issue logic and drop counter.

## Test plan
- Reset, gnt always 1, 1-cycle memory, inst_ready 1 → requests 0x0,0x4,0x8… one per cycle; inst_valid from cycle 2, inst_pc increments by 4 every cycle, no bubbles.
- inst_ready 0 for 10 cycles → exactly DEPTH=4 requests issued, imem_req then 0, inst_pc 0x0 held; release → 0x0,0x4,0x8,0xC in order, fetching resumes at 0x10.
- Redirect to 0x0000_0103 with 2 responses outstanding → next imem_addr 0x0000_0100 only after 2 responses are dropped; first delivered inst_pc 0x100.
- Redirect in same cycle as pop and rvalid → popped instruction not repeated, arriving word discarded, no stale inst_pc appears.
- gnt stalled 3 cycles → imem_addr/imem_req stable; wrap test from redirect 0xFFFF_FFF8 → 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst pulse mid-stream → inst_valid/imem_req 0 immediately; after release, first request addr RESET_PC.
